// File: rtl/mips_alu_seq.sv
// Sequential MIPS ALU: single-cycle logic/arith ops, iterative 32-step MUL/DIV/DIVU.
// Define ALU_FAST_MUL_EN to make MUL a single-cycle combinational multiply.
module mips_alu_seq #(
  parameter int WIDTH     = 32,
  parameter int ITER_BITS = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             alu_start,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [5:0]       aluctl,
  output logic [WIDTH-1:0] alu_out_data,
  output logic             alu_ready,
  output logic             alu_busy,
  output logic             alu_ovf,
  output logic             alu_illegal
);

  localparam logic [5:0] OP_ADD  = 6'd0;
  localparam logic [5:0] OP_ADDU = 6'd1;
  localparam logic [5:0] OP_SUB  = 6'd2;
  localparam logic [5:0] OP_SUBU = 6'd3;
  localparam logic [5:0] OP_AND  = 6'd4;
  localparam logic [5:0] OP_OR   = 6'd5;
  localparam logic [5:0] OP_XOR  = 6'd6;
  localparam logic [5:0] OP_NOR  = 6'd7;
  localparam logic [5:0] OP_SLT  = 6'd8;
  localparam logic [5:0] OP_SLTU = 6'd9;
  localparam logic [5:0] OP_SLL  = 6'd10;
  localparam logic [5:0] OP_SRL  = 6'd11;
  localparam logic [5:0] OP_SRA  = 6'd12;
  localparam logic [5:0] OP_LUI  = 6'd13;
  localparam logic [5:0] OP_MUL  = 6'd14;
  localparam logic [5:0] OP_DIV  = 6'd15;
  localparam logic [5:0] OP_DIVU = 6'd16;

  localparam logic [WIDTH-1:0]     ZERO_W = {WIDTH{1'b0}};
  localparam logic [ITER_BITS-1:0] CNT_0  = {ITER_BITS{1'b0}};
  localparam logic [ITER_BITS-1:0] CNT_1  = {{(ITER_BITS-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DIV, ST_DONE} state_t;

  state_t               state_r, state_s;
  logic [ITER_BITS-1:0] cnt_r, cnt_s;
  logic [WIDTH-1:0]     acc_r, acc_s;   // MUL accumulator / DIV remainder
  logic [WIDTH-1:0]     opa_r, opa_s;   // multiplicand / dividend-then-quotient
  logic [WIDTH-1:0]     opb_r, opb_s;   // multiplier / divisor
  logic                 neg_r, neg_s;
  logic [WIDTH-1:0]     out_r, out_s;
  logic                 ready_r, ready_s;
  logic                 busy_r, busy_s;
  logic                 ovf_r, ovf_s;
  logic                 ill_r, ill_s;

  logic [WIDTH-1:0]     sum_s, diff_s, single_res_s;
  logic                 single_ovf_s, single_ill_s, is_mul_s, is_div_s, is_sdiv_s;
  logic [WIDTH-1:0]     a_mag_s, b_mag_s;
  logic [WIDTH-1:0]     mul_acc_s, div_low_s, div_q_s, div_rem_s, div_res_s;
  logic                 div_ge_s;
  logic [ITER_BITS-1:0] shamt_s;

  assign sum_s   = A + B;
  assign diff_s  = A - B;
  assign shamt_s = A[ITER_BITS-1:0];

  // Decode and evaluate the single-cycle operations
  always_comb begin
    single_res_s = ZERO_W;
    single_ovf_s = 1'b0;
    single_ill_s = 1'b0;
    is_mul_s     = 1'b0;
    is_div_s     = 1'b0;
    is_sdiv_s    = 1'b0;
    case (aluctl)
      OP_ADD: begin
        single_res_s = sum_s;
        single_ovf_s = (A[WIDTH-1] == B[WIDTH-1]) && (sum_s[WIDTH-1] != A[WIDTH-1]);
      end
      OP_ADDU: single_res_s = sum_s;
      OP_SUB: begin
        single_res_s = diff_s;
        single_ovf_s = (A[WIDTH-1] != B[WIDTH-1]) && (diff_s[WIDTH-1] != A[WIDTH-1]);
      end
      OP_SUBU: single_res_s = diff_s;
      OP_AND:  single_res_s = A & B;
      OP_OR:   single_res_s = A | B;
      OP_XOR:  single_res_s = A ^ B;
      OP_NOR:  single_res_s = ~(A | B);
      OP_SLT:  single_res_s = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
      OP_SLTU: single_res_s = {{(WIDTH-1){1'b0}}, (A < B)};
      OP_SLL:  single_res_s = B << shamt_s;
      OP_SRL:  single_res_s = B >> shamt_s;
      OP_SRA:  single_res_s = $signed(B) >>> shamt_s;
      OP_LUI:  single_res_s = {B[WIDTH/2-1:0], {(WIDTH/2){1'b0}}};
`ifdef ALU_FAST_MUL_EN
      OP_MUL:  single_res_s = A * B;
`else
      OP_MUL:  is_mul_s = 1'b1;
`endif
      OP_DIV: begin
        is_div_s  = 1'b1;
        is_sdiv_s = 1'b1;
      end
      OP_DIVU: is_div_s = 1'b1;
      default: single_ill_s = 1'b1;
    endcase
  end

  assign a_mag_s = (is_sdiv_s && A[WIDTH-1]) ? (ZERO_W - A) : A;
  assign b_mag_s = (is_sdiv_s && B[WIDTH-1]) ? (ZERO_W - B) : B;

  // One iteration step: shift-add for MUL, restoring subtract for DIV.
  // The shifted-out remainder MSB forces "fits", so everything stays WIDTH bits.
  assign mul_acc_s = acc_r + (opb_r[0] ? opa_r : ZERO_W);
  assign div_low_s = {acc_r[WIDTH-2:0], opa_r[WIDTH-1]};
  assign div_ge_s  = acc_r[WIDTH-1] | (div_low_s >= opb_r);
  assign div_rem_s = div_ge_s ? (div_low_s - opb_r) : div_low_s;
  assign div_q_s   = {opa_r[WIDTH-2:0], div_ge_s};
  assign div_res_s = neg_r ? (ZERO_W - div_q_s) : div_q_s;

  // Next-state and next-output logic
  always_comb begin
    state_s = state_r;
    cnt_s   = cnt_r;
    acc_s   = acc_r;
    opa_s   = opa_r;
    opb_s   = opb_r;
    neg_s   = neg_r;
    out_s   = out_r;
    ready_s = 1'b0;
    ovf_s   = ovf_r;
    ill_s   = ill_r;
    case (state_r)
      ST_IDLE: begin
        if (alu_start) begin
          if (is_mul_s || is_div_s) begin
            state_s = is_mul_s ? ST_MUL : ST_DIV;
            cnt_s   = {ITER_BITS{1'b1}};
            acc_s   = ZERO_W;
            opa_s   = is_mul_s ? A : a_mag_s;
            opb_s   = is_mul_s ? B : b_mag_s;
            neg_s   = is_sdiv_s && (A[WIDTH-1] ^ B[WIDTH-1]) && (B != ZERO_W);
            ovf_s   = 1'b0;
            ill_s   = 1'b0;
          end else begin
            state_s = ST_DONE;
            out_s   = single_res_s;
            ovf_s   = single_ovf_s;
            ill_s   = single_ill_s;
            ready_s = 1'b1;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_MUL: begin
        acc_s = mul_acc_s;
        opa_s = opa_r << 1;
        opb_s = opb_r >> 1;
        cnt_s = cnt_r - CNT_1;
        if (cnt_r == CNT_0) begin
          state_s = ST_DONE;
          out_s   = mul_acc_s;
          ready_s = 1'b1;
        end else begin
          state_s = ST_MUL;
        end
      end
      ST_DIV: begin
        acc_s = div_rem_s;
        opa_s = div_q_s;
        cnt_s = cnt_r - CNT_1;
        if (cnt_r == CNT_0) begin
          state_s = ST_DONE;
          out_s   = div_res_s;
          ready_s = 1'b1;
        end else begin
          state_s = ST_DIV;
        end
      end
      ST_DONE: state_s = ST_IDLE;
      default: state_s = ST_IDLE;
    endcase
    busy_s = (state_s != ST_IDLE);
  end

  // State and registered outputs; synchronous reset aborts any op in flight
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      cnt_r   <= CNT_0;
      acc_r   <= ZERO_W;
      opa_r   <= ZERO_W;
      opb_r   <= ZERO_W;
      neg_r   <= 1'b0;
      out_r   <= ZERO_W;
      ready_r <= 1'b0;
      busy_r  <= 1'b0;
      ovf_r   <= 1'b0;
      ill_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      acc_r   <= acc_s;
      opa_r   <= opa_s;
      opb_r   <= opb_s;
      neg_r   <= neg_s;
      out_r   <= out_s;
      ready_r <= ready_s;
      busy_r  <= busy_s;
      ovf_r   <= ovf_s;
      ill_r   <= ill_s;
    end
  end

  assign alu_out_data = out_r;
  assign alu_ready    = ready_r;
  assign alu_busy     = busy_r;
  assign alu_ovf      = ovf_r;
  assign alu_illegal  = ill_r;

endmodule
